// File: rtl/fx1_result_pipe_pkg.sv
// Shared constants and types for the FX1 result/writeback pipeline.
// Instruction IDs follow the opcode_package.vh encoding (FX1 subset shown).
package fx1_result_pipe_pkg;

    localparam int FX1_LATENCY = 2;
    localparam int REG_ADDR_W  = 7;
    localparam int SPU_DATA_W  = 128;
    localparam int INSTR_ID_W  = 7;

    typedef enum logic [INSTR_ID_W-1:0] {
        ID_NOP  = 7'd0,
        ID_ADD  = 7'd1,
        ID_SUB  = 7'd2,
        ID_AND  = 7'd3,
        ID_OR   = 7'd4,
        ID_XOR  = 7'd5,
        ID_ADDI = 7'd6,
        ID_CEQ  = 7'd7
    } instr_id_e;

    // Per-stage shift control: load = advance one position, kill = drop the valid bit.
    typedef struct packed {
        logic load;
        logic kill;
    } stage_ctrl_t;

endpackage

// File: rtl/fx1_pipe_stage.sv
// One register stage of the FX1 result pipe: holds valid/payload, loads on
// ctrl.load and clears the incoming valid when ctrl.kill is set.
module fx1_pipe_stage
    import fx1_result_pipe_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = SPU_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  stage_ctrl_t           ctrl,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic [ADDR_W-1:0]     in_rt,
    input  logic [INSTR_ID_W-1:0] in_id,
    input  logic [0:DATA_W-1]     in_data,
    output logic                  out_valid,
    output logic                  out_reg_write,
    output logic [ADDR_W-1:0]     out_rt,
    output logic [INSTR_ID_W-1:0] out_id,
    output logic [0:DATA_W-1]     out_data
);

    logic                  valid_d, valid_q;
    logic                  reg_write_d, reg_write_q;
    logic [ADDR_W-1:0]     rt_d, rt_q;
    logic [INSTR_ID_W-1:0] id_d, id_q;
    logic [0:DATA_W-1]     data_d, data_q;

    // Payload follows every shift; only the valid bit is subject to kill.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rt_d        = rt_q;
        id_d        = id_q;
        data_d      = data_q;
        if (ctrl.load) begin
            valid_d     = in_valid & ~ctrl.kill;
            reg_write_d = in_reg_write;
            rt_d        = in_rt;
            id_d        = in_id;
            data_d      = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rt_q        <= '0;
            id_q        <= '0;
            data_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rt_q        <= rt_d;
            id_q        <= id_d;
            data_q      <= data_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_reg_write = reg_write_q;
    assign out_rt        = rt_q;
    assign out_id        = id_q;
    assign out_data      = data_q;

endmodule

// File: rtl/fx1_result_pipe.sv
// FX1 result pipeline: DEPTH register stages with stall/flush, one writeback
// port and per-stage forwarding buses for the bypass network.
module fx1_result_pipe
    import fx1_result_pipe_pkg::*;
#(
    parameter int DEPTH  = FX1_LATENCY,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = SPU_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [INSTR_ID_W-1:0]    in_instr_id,
    input  logic [ADDR_W-1:0]        in_rt_addr,
    input  logic                     in_reg_write,
    input  logic [0:DATA_W-1]        in_result,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     wb_valid,
    output logic                     wb_reg_write,
    output logic [ADDR_W-1:0]        wb_rt_addr,
    output logic [INSTR_ID_W-1:0]    wb_instr_id,
    output logic [0:DATA_W-1]        wb_result,
    output logic [DEPTH-1:0]         fwd_valid,
    output logic [DEPTH*ADDR_W-1:0]  fwd_rt_addr,
    output logic [DEPTH*DATA_W-1:0]  fwd_data,
    output logic                     busy
);

    // Index 0 is the issue slot; index k is register stage k.
    logic                  s_valid     [0:DEPTH];
    logic                  s_reg_write [0:DEPTH];
    logic [ADDR_W-1:0]     s_rt        [0:DEPTH];
    logic [INSTR_ID_W-1:0] s_id        [0:DEPTH];
    logic [0:DATA_W-1]     s_data      [0:DEPTH];

    stage_ctrl_t stage_ctrl;

    // Flush outranks stall: the pipe still shifts so the writeback stage
    // retires normally, but every valid bit entering a stage is cleared.
    always_comb begin
        stage_ctrl.load = flush | ~stall;
        stage_ctrl.kill = flush;
    end

    assign s_valid[0]     = in_valid;
    assign s_reg_write[0] = in_reg_write;
    assign s_rt[0]        = in_rt_addr;
    assign s_id[0]        = in_instr_id;
    assign s_data[0]      = in_result;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        fx1_pipe_stage #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk           (clk),
            .rst           (rst),
            .ctrl          (stage_ctrl),
            .in_valid      (s_valid[k-1]),
            .in_reg_write  (s_reg_write[k-1]),
            .in_rt         (s_rt[k-1]),
            .in_id         (s_id[k-1]),
            .in_data       (s_data[k-1]),
            .out_valid     (s_valid[k]),
            .out_reg_write (s_reg_write[k]),
            .out_rt        (s_rt[k]),
            .out_id        (s_id[k]),
            .out_data      (s_data[k])
        );
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_fwd
        assign fwd_valid[k]                     = s_valid[k+1] & s_reg_write[k+1];
        assign fwd_rt_addr[k*ADDR_W +: ADDR_W]  = s_rt[k+1];
        assign fwd_data[k*DATA_W +: DATA_W]     = s_data[k+1];
    end

    assign wb_valid     = s_valid[DEPTH];
    assign wb_reg_write = s_valid[DEPTH] & s_reg_write[DEPTH];
    assign wb_rt_addr   = s_rt[DEPTH];
    assign wb_instr_id  = s_id[DEPTH];
    assign wb_result    = s_data[DEPTH];

    always_comb begin
        busy = 1'b0;
        for (int k = 1; k <= DEPTH; k++) busy = busy | s_valid[k];
    end

endmodule

// File: tb/tb_fx1_result_pipe.sv
// Directed bench for fx1_result_pipe (DEPTH=2) with a writeback scoreboard.
module tb_fx1_result_pipe;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 128;

    typedef struct {
        logic [6:0]   rt;
        logic [6:0]   id;
        logic [127:0] data;
        logic         rw;
    } sb_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [6:0]              in_instr_id;
    logic [ADDR_W-1:0]       in_rt_addr;
    logic                    in_reg_write;
    logic [0:DATA_W-1]       in_result;
    logic                    stall;
    logic                    flush;
    logic                    wb_valid;
    logic                    wb_reg_write;
    logic [ADDR_W-1:0]       wb_rt_addr;
    logic [6:0]              wb_instr_id;
    logic [0:DATA_W-1]       wb_result;
    logic [DEPTH-1:0]        fwd_valid;
    logic [DEPTH*ADDR_W-1:0] fwd_rt_addr;
    logic [DEPTH*DATA_W-1:0] fwd_data;
    logic                    busy;

    int  tests = 0;
    int  fails = 0;
    sb_t sb[$];

    fx1_result_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr_id  (in_instr_id),
        .in_rt_addr   (in_rt_addr),
        .in_reg_write (in_reg_write),
        .in_result    (in_result),
        .stall        (stall),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rt_addr   (wb_rt_addr),
        .wb_instr_id  (wb_instr_id),
        .wb_result    (wb_result),
        .fwd_valid    (fwd_valid),
        .fwd_rt_addr  (fwd_rt_addr),
        .fwd_data     (fwd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the issue slot; when commit is set the instruction is expected at wb.
    task automatic issue(input logic [6:0] rt, input logic [127:0] data,
                         input logic [6:0] id, input logic rw, input bit commit);
        sb_t e;
        in_valid     = 1'b1;
        in_rt_addr   = rt;
        in_result    = data;
        in_instr_id  = id;
        in_reg_write = rw;
        if (commit) begin
            e.rt = rt; e.data = data; e.id = id; e.rw = rw;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Advance one edge and check any newly presented writeback against the scoreboard.
    task automatic tick();
        logic held;
        sb_t  e;
        held = stall & ~flush;
        @(posedge clk);
        #1;
        if (wb_valid && !held) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {249'd0, wb_rt_addr}, 256'h7f);
            end else begin
                e = sb.pop_front();
                chk("wb_rt",    wb_rt_addr,   e.rt);
                chk("wb_id",    wb_instr_id,  e.id);
                chk("wb_data",  wb_result,    e.data);
                chk("wb_rw",    wb_reg_write, e.rw);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wb_valid"}, wb_valid,     0);
        chk({tag, "_wb_rw"},    wb_reg_write, 0);
        chk({tag, "_wb_rt"},    wb_rt_addr,   0);
        chk({tag, "_wb_id"},    wb_instr_id,  0);
        chk({tag, "_wb_data"},  wb_result,    0);
        chk({tag, "_fwd_v"},    fwd_valid,    0);
        chk({tag, "_fwd_rt"},   fwd_rt_addr,  0);
        chk({tag, "_fwd_data"}, fwd_data,     0);
        chk({tag, "_busy"},     busy,         0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_instr_id = '0; in_rt_addr = '0;
        in_reg_write = 1'b0; in_result = '0;
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // Single instruction: 2-cycle latency, one-cycle writeback.
        issue(7'd5, {4{32'h0000_0001}}, 7'd1, 1'b1, 1);
        tick();
        idle();
        chk("t1_wb_early",  wb_valid,  0);
        chk("t1_fwd_v_s1",  fwd_valid, 2'b01);
        chk("t1_fwd_rt_s1", fwd_rt_addr[6:0], 7'd5);
        chk("t1_fwd_d_s1",  fwd_data[127:0], {4{32'h0000_0001}});
        tick();
        chk("t1_wb_valid",  wb_valid,  1);
        chk("t1_fwd_v_s2",  fwd_valid, 2'b10);
        tick();
        chk("t1_wb_once",   wb_valid,  0);
        chk("t1_busy",      busy,      0);

        // Back-to-back issue; rt=2 does not write so its forward bit stays low.
        issue(7'd1, {16{8'h11}}, 7'd2, 1'b1, 1);
        tick();
        issue(7'd2, {16{8'h22}}, 7'd3, 1'b0, 1);
        tick();
        chk("t2_fwd_rt_s1", fwd_rt_addr[6:0],  7'd2);
        chk("t2_fwd_rt_s2", fwd_rt_addr[13:7], 7'd1);
        chk("t2_fwd_v_a",   fwd_valid, 2'b10);
        chk("t2_wb_rt1",    wb_valid,  1);
        issue(7'd3, {16{8'h33}}, 7'd4, 1'b1, 1);
        tick();
        chk("t2_fwd_rt_s1b", fwd_rt_addr[6:0],  7'd3);
        chk("t2_fwd_rt_s2b", fwd_rt_addr[13:7], 7'd2);
        chk("t2_fwd_v_b",   fwd_valid, 2'b01);
        chk("t2_wb_rw0",    wb_reg_write, 0);
        idle();
        tick();
        chk("t2_wb_rt3",    wb_valid,  1);
        tick();
        chk("t2_busy",      busy,      0);

        // Stall for three cycles after the first edge; pulses during stall are ignored.
        issue(7'd7, {4{32'hdead_beef}}, 7'd5, 1'b1, 1);
        tick();
        stall = 1'b1;
        issue(7'd20, {4{32'hbad0_bad0}}, 7'd6, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_wb_held_off", wb_valid, 0);
            chk("t3_fwd_v_held",  fwd_valid, 2'b01);
            chk("t3_fwd_rt_held", fwd_rt_addr[6:0], 7'd7);
        end
        stall = 1'b0;
        idle();
        tick();
        chk("t3_wb_valid", wb_valid, 1);
        stall = 1'b1;
        tick();
        chk("t3_wb_stall_hold", wb_valid, 1);
        chk("t3_wb_stall_rt",   wb_rt_addr, 7'd7);
        stall = 1'b0;
        tick();
        chk("t3_busy", busy, 0);

        // Flush while rt=8 sits in stage 1, squashing it and the incoming rt=9.
        issue(7'd8, {4{32'h0808_0808}}, 7'd1, 1'b1, 0);
        tick();
        issue(7'd9, {4{32'h0909_0909}}, 7'd2, 1'b1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("t4_busy_a", busy, 0);
        tick();
        chk("t4_wb_none", wb_valid, 0);
        chk("t4_busy_b",  busy, 0);

        // Flush+stall with rt=10 on writeback: rt=10 still commits, pipe empties.
        issue(7'd10, {4{32'h1010_1010}}, 7'd3, 1'b1, 1);
        tick();
        issue(7'd11, {4{32'h1111_1111}}, 7'd4, 1'b1, 0);
        tick();
        issue(7'd12, {4{32'h1212_1212}}, 7'd5, 1'b1, 0);
        flush = 1'b1;
        stall = 1'b1;
        #1;
        chk("t5_wb_commit_v",  wb_valid, 1);
        chk("t5_wb_commit_we", wb_reg_write, 1);
        chk("t5_wb_commit_rt", wb_rt_addr, 7'd10);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        idle();
        chk("t5_wb_empty", wb_valid, 0);
        chk("t5_busy",     busy, 0);

        // Asynchronous reset with two instructions in flight.
        issue(7'd13, {4{32'h1313_1313}}, 7'd6, 1'b1, 1);
        tick();
        issue(7'd14, {4{32'h1414_1414}}, 7'd7, 1'b1, 0);
        tick();
        idle();
        chk("t6_busy_pre", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_wb",  wb_valid, 0);
            chk("t6_busy",   busy, 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
